// File: rtl/entropy_buf_ctrl_if.sv
// Control, entropy-source handshake and seed-buffer signals of entropy_buf_ctrl.
// slave = the controller, master = the surrounding source/consumer logic.
interface entropy_buf_ctrl_if #(
   parameter int TO_W = 16
);
   logic            trng_drng_sel;
   logic            trng_drng_sel_chg;
   logic            drng_reseed_req;
   logic [31:0]     ent_data;
   logic            ent_vld;
   logic            ent_rdy;
   logic            health_fail;
   logic            post_read;
   logic [TO_W-1:0] timeout_cfg;
   logic            err_clr;
   logic            buf_write;
   logic [2:0]      buf_addr;
   logic [255:0]    buf_data;
   logic            buf_ready;
   logic            fill_err;

   modport slave (
      input  trng_drng_sel, trng_drng_sel_chg, drng_reseed_req, ent_data, ent_vld,
             health_fail, post_read, timeout_cfg, err_clr,
      output ent_rdy, buf_write, buf_addr, buf_data, buf_ready, fill_err
   );

   modport master (
      output trng_drng_sel, trng_drng_sel_chg, drng_reseed_req, ent_data, ent_vld,
             health_fail, post_read, timeout_cfg, err_clr,
      input  ent_rdy, buf_write, buf_addr, buf_data, buf_ready, fill_err
   );
endinterface

// File: rtl/entropy_buf_ctrl.sv
// Seed buffer loader: 8 x 32b words, TRNG refills continuously, DRNG on reseed; all outputs registered.
// Backpressure via registered ent_rdy; optional ENT_BUF_ZERO_ON_READ_EN clears the seed on accepted post_read.
module entropy_buf_ctrl #(
   parameter int MAX_RETRY = 3,
   parameter int TO_W      = 16
) (
   input logic               clk,
   input logic               rst,
   entropy_buf_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2,
      ERR  = 2'd3
   } state_e;

   localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

   state_e          state_q, state_d;
   logic [2:0]      wcnt_q, wcnt_d;
   logic [3:0]      retry_q, retry_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [2:0]      buf_addr_q, buf_addr_d;
   logic [255:0]    buf_data_q, buf_data_d;
   logic            buf_write_q, buf_write_d;
   logic            ent_rdy_q, buf_ready_q, fill_err_q;

   logic            beat;
   logic [TO_W-1:0] to_inc;
   logic [3:0]      retry_inc;
   logic            to_hit;

   assign beat      = bus.ent_vld & ent_rdy_q;
   assign to_inc    = to_q + TO_W'(1);
   assign retry_inc = retry_q + 4'd1;
   assign to_hit    = (bus.timeout_cfg != '0) && (to_inc == bus.timeout_cfg);

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      retry_d     = retry_q;
      to_d        = to_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      buf_write_d = 1'b0;

      case (state_q)
         IDLE: begin
            to_d = '0;
            if (!bus.trng_drng_sel || bus.drng_reseed_req) begin
               state_d = FILL;
               wcnt_d  = '0;
            end
         end

         // Priority inside FILL: mode change, health failure, timeout, then the beat itself.
         FILL: begin
            if (bus.trng_drng_sel_chg) begin
               state_d = IDLE;
               wcnt_d  = '0;
               to_d    = '0;
            end else if (bus.health_fail) begin
               wcnt_d  = '0;
               retry_d = retry_inc;
               to_d    = beat ? '0 : to_inc;
               if (retry_inc == MAX_RETRY_C) begin
                  state_d = ERR;
               end
            end else if (!beat) begin
               to_d = to_inc;
               if (to_hit) begin
                  state_d = ERR;
               end
            end else begin
               buf_data_d[{wcnt_q, 5'd0} +: 32] = bus.ent_data;
               buf_write_d = 1'b1;
               buf_addr_d  = wcnt_q;
               to_d        = '0;
               wcnt_d      = wcnt_q + 3'd1;
               if (wcnt_q == 3'd7) begin
                  state_d = FULL;
                  retry_d = '0;
               end
            end
         end

         FULL: begin
            to_d = '0;
            if (bus.trng_drng_sel_chg) begin
               state_d = IDLE;
               wcnt_d  = '0;
            end else if (bus.post_read) begin
               state_d = bus.trng_drng_sel ? IDLE : FILL;
               wcnt_d  = '0;
`ifdef ENT_BUF_ZERO_ON_READ_EN
               buf_data_d = '0;
`endif
            end
         end

         ERR: begin
            if (bus.err_clr) begin
               state_d = IDLE;
               retry_d = '0;
               to_d    = '0;
               wcnt_d  = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Flag outputs follow the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         retry_q     <= '0;
         to_q        <= '0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         buf_write_q <= 1'b0;
         ent_rdy_q   <= 1'b0;
         buf_ready_q <= 1'b0;
         fill_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         retry_q     <= retry_d;
         to_q        <= to_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         buf_write_q <= buf_write_d;
         ent_rdy_q   <= (state_d == FILL);
         buf_ready_q <= (state_d == FULL);
         fill_err_q  <= (state_d == ERR);
      end
   end

   assign bus.ent_rdy   = ent_rdy_q;
   assign bus.buf_write = buf_write_q;
   assign bus.buf_addr  = buf_addr_q;
   assign bus.buf_data  = buf_data_q;
   assign bus.buf_ready = buf_ready_q;
   assign bus.fill_err  = fill_err_q;

endmodule

// File: doc/entropy_buf_ctrl.md
Name: entropy_buf_ctrl

Overview:
- Loads the 256-bit entropy seed buffer that the post-processing datapath consumes: 8 x 32-bit raw-entropy words drive the buf_write / buf_addr / buf_data / buf_ready interface.
- TRNG mode: refills continuously after each consume.
- DRNG mode: fills only when the post-processor raises drng_reseed_req.
- Adds fill timeout, health-failure restart and a sticky error.

Parameters:
- MAX_RETRY, 3, consecutive health-failure restarts allowed before entering ERR (range 1..15).
- TO_W, 16, width of the timeout counter and of timeout_cfg.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- trng_drng_sel  in  1  0 = TRNG mode, 1 = DRNG mode
- trng_drng_sel_chg  in  1  one-cycle pulse on a mode change
- drng_reseed_req  in  1  level request to fill (DRNG mode)
- ent_data  in  32  raw entropy word
- ent_vld  in  1  ent_data valid
- ent_rdy  out  1  controller accepts ent_data
- health_fail  in  1  health-test failure pulse from the noise source
- post_read  in  1  one-cycle pulse: consumer has taken the buffer
- timeout_cfg  in  TO_W  idle-cycle limit while filling; 0 = disabled
- err_clr  in  1  clears ERR
- buf_write  out  1  one-cycle pulse per word written
- buf_addr  out  3  index of the word just written
- buf_data  out  256  seed buffer
- buf_ready  out  1  buffer complete
- fill_err  out  1  sticky error flag

Behaviour:
- Reset: state IDLE; all outputs 0 (buf_data = 0, buf_addr = 0, ent_rdy = 0); word counter, retry counter and timeout counter = 0.
- States: IDLE, FILL, FULL, ERR. All outputs are registered.
- IDLE -> FILL:
  - when trng_drng_sel = 0, or
  - when trng_drng_sel = 1 and drng_reseed_req = 1.
  - Word counter clears on entry.
- FILL:
  - ent_rdy = 1 (registered; asserted the cycle after entering FILL).
  - Handshake beat = ent_vld & ent_rdy. On a beat at word index k: buf_data[32k+31:32k] <= ent_data; buf_write = 1 and buf_addr = k the next cycle; k increments.
  - The beat at k = 7 moves to FULL. buf_ready = 1 in the same cycle as that word's buf_write pulse. ent_rdy drops that cycle, so no further beat is accepted.
  - Words are written in order 0..7. Words already written stay in buf_data until overwritten.
- Health failure in FILL:
  - Discard the progress: word counter = 0, retry counter +1, stay in FILL.
  - If a beat coincides with health_fail, health_fail wins and the word is not written (no buf_write).
  - A health_fail that makes the retry counter reach MAX_RETRY -> ERR.
  - The retry counter clears on a successful FULL.
- Timeout:
  - The counter increments every FILL cycle with no beat and clears on each beat.
  - Counter == timeout_cfg (timeout_cfg != 0) -> ERR.
- FULL:
  - buf_ready = 1, ent_rdy = 0.
  - On post_read: buf_ready = 0 next cycle; TRNG mode -> FILL; DRNG mode -> IDLE.
  - post_read in any state other than FULL is ignored.
- ERR:
  - fill_err = 1, ent_rdy = 0, buf_ready = 0.
  - Exit to IDLE only on err_clr: fill_err, retry counter and timeout counter clear.
- trng_drng_sel_chg:
  - From FILL or FULL: -> IDLE next cycle; buf_ready = 0, word counter = 0; no buf_write that cycle; a coincident beat is dropped.
  - In ERR: ignored.
- Priority when events coincide: rst > err_clr (ERR only) > trng_drng_sel_chg > health_fail > timeout > beat.
- Reset mid-fill: returns to the reset state; buf_data is zeroed.

Optional Feature:
- Macro: ENT_BUF_ZERO_ON_READ_EN.
- Defined: the post_read that is accepted in FULL also sets buf_data = 0 on the next cycle, the same cycle buf_ready falls. This prevents the seed being reused or read back.
- Undefined: buf_data holds its last contents until overwritten word by word.

Test Plan:
- TRNG fill:
  - Stimulus: trng_drng_sel = 0, ent_vld held 1, words 0x1000_0000+k.
  - Required: 8 buf_write pulses with buf_addr 0..7; buf_ready = 1 with the addr-7 pulse; buf_data[255:224] = 0x1000_0007.
  - Then post_read: buf_ready = 0 and the refill restarts at addr 0.
- DRNG gating:
  - Stimulus: trng_drng_sel = 1, drng_reseed_req = 0 for 50 cycles.
  - Required: ent_rdy stays 0.
  - Then raise drng_reseed_req: fill completes; after post_read the block returns to IDLE and ent_rdy = 0.
- Health failure:
  - Stimulus: health_fail coincident with the beat at word 5.
  - Required: no buf_write for that beat; the next beat writes buf_addr 0.
  - With MAX_RETRY = 3, the third consecutive failure -> fill_err = 1, ent_rdy = 0.
  - err_clr -> fill_err = 0, state IDLE.
- Timeout:
  - Stimulus: timeout_cfg = 10, ent_vld = 0 in FILL.
  - Required: fill_err = 1 after 10 idle cycles.
  - timeout_cfg = 0: no error after 1000 idle cycles.
- Mode change:
  - Stimulus: trng_drng_sel_chg pulse at word 3 (with a coincident beat), and separately while in FULL.
  - Required: no buf_write; buf_ready = 0; the next fill starts at addr 0.
- Zeroize:
  - With ENT_BUF_ZERO_ON_READ_EN defined, post_read in FULL -> buf_data = 0 one cycle later.
  - With the macro undefined, buf_data is unchanged.
